// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / hazard unit.
package fwd_pkg;

   // Forwarding select encodings for one EX operand
   localparam logic [1:0] FWD_RF  = 2'b00;  // register-file operand
   localparam logic [1:0] FWD_MEM = 2'b01;  // aluout_EXE_MEM
   localparam logic [1:0] FWD_WB  = 2'b10;  // MEM/WB writeback

   // Tag slots carry a fixed-width rd field; REG_AW of the unit must not exceed it.
   localparam int unsigned TAG_AW = 8;

   typedef struct packed {
      logic              valid;
      logic [TAG_AW-1:0] rd;
      logic              we;
      logic              is_load;
   } tag_slot_t;

   localparam tag_slot_t EMPTY_SLOT = '0;

endpackage

// File: rtl/fwd_match.sv
// Compares one source register against one pipeline tag slot.
// Splits the hit by producer kind so callers can tell load-use from ALU forwarding.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int unsigned REG_AW = 5
) (
   input  tag_slot_t         slot,
   input  logic [REG_AW-1:0] rs,
   output logic              hit_alu,
   output logic              hit_load
);

   logic hit;

   // Register 0 is hard-wired, so it never matches a producer
   always_comb begin
      hit      = slot.valid & slot.we & (slot.rd == TAG_AW'(rs)) & (rs != '0);
      hit_alu  = hit & ~slot.is_load;
      hit_load = hit & slot.is_load;
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit for the 5-stage core.
// Tracks destination tags of instructions in EX and MEM, raises a combinational
// stall at ID, and registers per-operand forwarding selects into EX.
// No WB tag is kept: the register file is write-before-read, so a producer in
// WB is already visible to the ID read and never needs a stall or forward.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned FWD_EN = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     id_valid,
   input  logic [NUM_RD*REG_AW-1:0] id_rs,
   input  logic [NUM_RD-1:0]        id_rs_used,
   input  logic [REG_AW-1:0]        id_rd,
   input  logic                     id_we,
   input  logic                     id_is_load,
   input  logic                     flush,
   output logic                     stall,
   output logic [NUM_RD*2-1:0]      fwd_sel,
   input  logic [NUM_RD*DATA_W-1:0] ex_rdata,
   input  logic [DATA_W-1:0]        mem_alu,
   input  logic [DATA_W-1:0]        wb_data,
   output logic [NUM_RD*DATA_W-1:0] ex_opnd,
   output logic                     ex_valid
);

   tag_slot_t slot_ex_q, slot_mem_q, slot_id;

   logic [NUM_RD-1:0]   ex_alu_hit, ex_ld_hit, mem_alu_hit, mem_ld_hit;
   logic [NUM_RD-1:0]   port_hazard;
   logic [NUM_RD*2-1:0] fwd_sel_d, fwd_sel_q;
   logic                enter_ex;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_port
      fwd_match #(.REG_AW(REG_AW)) u_match_ex (
         .slot     (slot_ex_q),
         .rs       (id_rs[k*REG_AW +: REG_AW]),
         .hit_alu  (ex_alu_hit[k]),
         .hit_load (ex_ld_hit[k])
      );
      fwd_match #(.REG_AW(REG_AW)) u_match_mem (
         .slot     (slot_mem_q),
         .rs       (id_rs[k*REG_AW +: REG_AW]),
         .hit_alu  (mem_alu_hit[k]),
         .hit_load (mem_ld_hit[k])
      );
   end

   // Per-port hazard, stall decision and the ID->EX advance condition
   always_comb begin
      port_hazard = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (FWD_EN != 0) begin
            // Only a load in EX cannot be forwarded in time
            port_hazard[k] = id_rs_used[k] & ex_ld_hit[k];
         end else begin
            // Interlock until the producer has reached WB
            port_hazard[k] = id_rs_used[k] &
                             (ex_alu_hit[k] | ex_ld_hit[k] | mem_alu_hit[k] | mem_ld_hit[k]);
         end
      end
      // Flush wins over stall: the killed instruction must not hold the front end
      stall    = id_valid & ~flush & (|port_hazard);
      enter_ex = id_valid & ~stall & ~flush;
      slot_id  = '{valid: 1'b1, rd: TAG_AW'(id_rd), we: id_we, is_load: id_is_load};
   end

   // Forwarding selects for the instruction about to enter EX; youngest producer wins
   always_comb begin
      fwd_sel_d = '0;
      if (enter_ex && (FWD_EN != 0)) begin
         for (int k = 0; k < NUM_RD; k++) begin
            if (ex_alu_hit[k]) begin
               fwd_sel_d[k*2 +: 2] = FWD_MEM;
            end else if (mem_alu_hit[k] | mem_ld_hit[k]) begin
               fwd_sel_d[k*2 +: 2] = FWD_WB;
            end else begin
               fwd_sel_d[k*2 +: 2] = FWD_RF;
            end
         end
      end
   end

   // Tag pipeline and registered selects; a non-advancing ID inserts a bubble
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_ex_q  <= EMPTY_SLOT;
         slot_mem_q <= EMPTY_SLOT;
         fwd_sel_q  <= '0;
      end else begin
         slot_mem_q <= slot_ex_q;
         slot_ex_q  <= enter_ex ? slot_id : EMPTY_SLOT;
         fwd_sel_q  <= fwd_sel_d;
      end
   end

   // EX operand muxes; the unused 2'b11 code falls back to the register file
   always_comb begin
      ex_opnd = ex_rdata;
      for (int k = 0; k < NUM_RD; k++) begin
         case (fwd_sel_q[k*2 +: 2])
            FWD_MEM: ex_opnd[k*DATA_W +: DATA_W] = mem_alu;
            FWD_WB:  ex_opnd[k*DATA_W +: DATA_W] = wb_data;
            default: ex_opnd[k*DATA_W +: DATA_W] = ex_rdata[k*DATA_W +: DATA_W];
         endcase
      end
   end

   assign fwd_sel  = fwd_sel_q;
   assign ex_valid = slot_ex_q.valid;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one forwarding build and one interlock-only
// build share the ID-side stimulus; expected EX-stage results are queued when an
// instruction is presented and compared after the next rising edge.
module tb_fwd_hazard_unit;

   localparam logic [31:0] RDATA0 = 32'hAAAA_0000;
   localparam logic [31:0] RDATA1 = 32'hBBBB_1111;
   localparam logic [31:0] MEMALU = 32'h0000_0010;
   localparam logic [31:0] WBDATA = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [9:0]  id_rs;
   logic [1:0]  id_rs_used;
   logic [4:0]  id_rd;
   logic        id_we;
   logic        id_is_load;
   logic        flush;
   logic [63:0] ex_rdata;
   logic [31:0] mem_alu;
   logic [31:0] wb_data;

   logic        stall_f, stall_i;
   logic [3:0]  fwd_sel_f, fwd_sel_i;
   logic [63:0] ex_opnd_f, ex_opnd_i;
   logic        ex_valid_f, ex_valid_i;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      bit         fwd;    // 1: forwarding build, 0: interlock-only build
      string      tag;
      logic       valid;
      logic [3:0] sel;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .NUM_RD(2), .FWD_EN(1)) u_dut_fwd (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rs_used (id_rs_used),
      .id_rd      (id_rd),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .flush      (flush),
      .stall      (stall_f),
      .fwd_sel    (fwd_sel_f),
      .ex_rdata   (ex_rdata),
      .mem_alu    (mem_alu),
      .wb_data    (wb_data),
      .ex_opnd    (ex_opnd_f),
      .ex_valid   (ex_valid_f)
   );

   fwd_hazard_unit #(.DATA_W(32), .REG_AW(5), .NUM_RD(2), .FWD_EN(0)) u_dut_ilk (
      .clk        (clk),
      .rst        (rst),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rs_used (id_rs_used),
      .id_rd      (id_rd),
      .id_we      (id_we),
      .id_is_load (id_is_load),
      .flush      (flush),
      .stall      (stall_i),
      .fwd_sel    (fwd_sel_i),
      .ex_rdata   (ex_rdata),
      .mem_alu    (mem_alu),
      .wb_data    (wb_data),
      .ex_opnd    (ex_opnd_i),
      .ex_valid   (ex_valid_i)
   );

   function automatic logic [31:0] opnd_of(input logic [1:0] s, input int k);
      case (s)
         2'b01:   return MEMALU;
         2'b10:   return WBDATA;
         default: return (k == 0) ? RDATA0 : RDATA1;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stall(input bit fwd, input string tag, input logic exp);
      chk({tag, "/stall"}, 64'(fwd ? stall_f : stall_i), 64'(exp));
   endtask

   task automatic expect_ex(input bit fwd, input string tag, input logic v, input logic [3:0] sel);
      exp_t e;
      e.fwd = fwd; e.tag = tag; e.valid = v; e.sel = sel;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t        e;
      logic [63:0] op;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e  = sb.pop_front();
         op = {opnd_of(e.sel[3:2], 1), opnd_of(e.sel[1:0], 0)};
         if (e.fwd) begin
            chk({e.tag, "/ex_valid"}, 64'(ex_valid_f), 64'(e.valid));
            chk({e.tag, "/fwd_sel"},  64'(fwd_sel_f),  64'(e.sel));
            chk({e.tag, "/ex_opnd"},  ex_opnd_f,       op);
         end else begin
            chk({e.tag, "/ex_valid"}, 64'(ex_valid_i), 64'(e.valid));
            chk({e.tag, "/fwd_sel"},  64'(fwd_sel_i),  64'(e.sel));
            chk({e.tag, "/ex_opnd"},  ex_opnd_i,       op);
         end
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] used, input logic [4:0] rd, input logic we,
                        input logic ld, input logic fl);
      id_valid = v; id_rs = {rs1, rs0}; id_rs_used = used;
      id_rd = rd; id_we = we; id_is_load = ld; flush = fl;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "/f_ex_valid"}, 64'(ex_valid_f), 64'(0));
      chk({tag, "/f_fwd_sel"},  64'(fwd_sel_f),  64'(0));
      chk({tag, "/f_stall"},    64'(stall_f),    64'(0));
      chk({tag, "/f_ex_opnd"},  ex_opnd_f,       {RDATA1, RDATA0});
      chk({tag, "/i_ex_valid"}, 64'(ex_valid_i), 64'(0));
      chk({tag, "/i_fwd_sel"},  64'(fwd_sel_i),  64'(0));
      chk({tag, "/i_ex_opnd"},  ex_opnd_i,       {RDATA1, RDATA0});
   endtask

   task automatic do_reset(input string tag);
      idle();
      rst = 1'b0;
      #1;
      chk_reset_state(tag);
      @(posedge clk);
      #2;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      ex_rdata = {RDATA1, RDATA0};
      mem_alu  = MEMALU;
      wb_data  = WBDATA;
      idle();
      rst = 1'b1;
      #1;
      do_reset("reset0");

      // Back-to-back ALU dependency: add r3 ; sub r4,r3,r1
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(1, "alu_prod", 1'b0);
      expect_ex(1, "alu_prod", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(1, "alu_cons", 1'b0);
      expect_ex(1, "alu_cons", 1'b1, 4'b0001);
      tick();
      idle();
      expect_ex(1, "alu_idle", 1'b0, 4'b0000);
      tick();

      // Load-use: lw r5 ; add r6,r5,r5 -> exactly one stall, then WB forward on both ports
      drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0);
      #1 chk_stall(1, "lw", 1'b0);
      expect_ex(1, "lw", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(1, "lu_stall", 1'b1);
      expect_ex(1, "lu_bubble", 1'b0, 4'b0000);
      tick();
      #1 chk_stall(1, "lu_release", 1'b0);
      expect_ex(1, "lu_cons", 1'b1, 4'b1010);
      tick();
      idle();
      expect_ex(1, "lu_idle", 1'b0, 4'b0000);
      tick();

      // r0 producer followed by a reader of r0: no stall, no forward
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(1, "r0_prod", 1'b0);
      expect_ex(1, "r0_prod", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd9, 1'b0, 1'b0, 1'b0);
      #1 chk_stall(1, "r0_cons", 1'b0);
      expect_ex(1, "r0_cons", 1'b1, 4'b0000);
      tick();

      // Two producers of r2: the younger one (in EX) wins on port 1
      drive(1'b1, 5'd1, 5'd1, 2'b11, 5'd2, 1'b1, 1'b0, 1'b0);
      expect_ex(1, "dbl_old", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd1, 5'd1, 2'b11, 5'd2, 1'b1, 1'b0, 1'b0);
      expect_ex(1, "dbl_young", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(1, "dbl_cons", 1'b0);
      expect_ex(1, "dbl_cons", 1'b1, 4'b0100);
      tick();
      idle();
      expect_ex(1, "dbl_idle", 1'b0, 4'b0000);
      tick();

      // Interlock-only build: add r7 ; or r8,r7,r0 -> two stall cycles, selects stay 00
      do_reset("reset1");
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(0, "ilk_prod", 1'b0);
      expect_ex(0, "ilk_prod", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(0, "ilk_st1", 1'b1);
      expect_ex(0, "ilk_st1", 1'b0, 4'b0000);
      tick();
      #1 chk_stall(0, "ilk_st2", 1'b1);
      expect_ex(0, "ilk_st2", 1'b0, 4'b0000);
      tick();
      #1 chk_stall(0, "ilk_go", 1'b0);
      expect_ex(0, "ilk_cons", 1'b1, 4'b0000);
      tick();
      idle();
      expect_ex(0, "ilk_idle", 1'b0, 4'b0000);
      tick();

      // Same pair with a flush in the first stall cycle: flush wins, bubble enters EX
      drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
      expect_ex(0, "fl_prod", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b1);
      #1 chk_stall(0, "fl_flush", 1'b0);
      expect_ex(0, "fl_bubble", 1'b0, 4'b0000);
      tick();
      drive(1'b1, 5'd7, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(0, "fl_st", 1'b1);
      expect_ex(0, "fl_st", 1'b0, 4'b0000);
      tick();
      #1 chk_stall(0, "fl_go", 1'b0);
      expect_ex(0, "fl_cons", 1'b1, 4'b0000);
      tick();

      // Asynchronous reset with a load in EX: state is dropped immediately
      idle();
      expect_ex(1, "ar_idle", 1'b0, 4'b0000);
      tick();
      drive(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b0);
      expect_ex(1, "ar_lw", 1'b1, 4'b0000);
      tick();
      drive(1'b1, 5'd5, 5'd5, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
      #1 chk_stall(1, "ar_pre", 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("ar_ex_valid", 64'(ex_valid_f), 64'(0));
      chk("ar_fwd_sel",  64'(fwd_sel_f),  64'(0));
      chk_stall(1, "ar_in_reset", 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_stall(1, "ar_post", 1'b0);
      expect_ex(1, "ar_cons", 1'b1, 4'b0000);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
